sha256_msg_schedule: RTL
========================

Name: sha256_msg_schedule

Overview:
- Message-schedule stage directly upstream of the SHA-256 compression rounds.
- Accepts one 512-bit padded message block and emits the 64 schedule words W[0..63], one per handshake, in round order.
- Each W[t] is paired by the round logic with round constant K[t].
- Uses a 16-word sliding window; no 64-entry storage.

Parameters:
- LAST_IDX, 63, index of the final emitted word. 63 is required for SHA-256; smaller values (16..62) are for debug benches only.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- blk_valid  in  1  upstream block available.
- blk_ready  out  1  block accepted when blk_valid && blk_ready.
- blk_data  in  512  block; W[0] = bits 511:480 … W[15] = bits 31:0 (big-endian word order).
- w_valid  out  1  w_data holds a valid schedule word.
- w_ready  in  1  downstream accepts word when w_valid && w_ready.
- w_data  out  32  current schedule word W[t].
- w_idx  out  6  t of current word.
- w_last  out  1  high with w_valid when w_idx == LAST_IDX.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - state = IDLE; w_valid = 0; w_idx = 0; w_last = 0.
  - w_data = 0; window cleared.
  - blk_ready = 1 once in IDLE.
- States:
  - IDLE: blk_ready = 1, w_valid = 0. On block handshake, load window[0..15] = W[0..15], t = 0, go to RUN.
  - RUN: blk_ready = 0 (see Optional Feature); w_valid = 1; w_data = window[0]; w_idx = t.
- Latency: block accepted at edge N → w_valid = 1 and w_data = W[0] after edge N, i.e. visible in cycle N+1.
- On word handshake in RUN:
  - Shift window down one word: window[i] ← window[i+1].
  - window[15] ← σ1(window[14]) + window[9] + σ0(window[1]) + window[0].
  - t ← t+1.
- Arithmetic:
  - All additions modulo 2^32; carries discarded.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Word ordering: W[0..15] are emitted unmodified from the block; W[16..] are computed by the window recurrence.
- Backpressure: while w_valid && !w_ready, w_data, w_idx, w_last and the window hold exactly; no skipped or repeated words.
- End of block: handshake with t == LAST_IDX → IDLE; w_valid = 0 next cycle; blk_ready = 1.
- blk_valid is ignored in RUN. blk_data is sampled only at handshake, so upstream may change it afterwards.
- Reset mid-block discards the block. After deassert the block is in IDLE and no stale words are emitted.
- w_valid never drops without a handshake except by reset.

Optional Feature:
- Macro: SHA256_SCHED_BACK2BACK_EN.
- Defined:
  - blk_ready = IDLE || (RUN && w_last && w_ready).
  - A block handshake in the same cycle as the last word handshake loads the new window and stays in RUN with t = 0.
  - Throughput is 64 words per 64 cycles with no bubble.
- Undefined:
  - blk_ready only in IDLE.
  - One idle cycle between blocks: the last word is at cycle M, W[0] of the next block at cycle M+2 at the earliest.

Test Plan:
- All-zero block, w_ready = 1 → 64 words all 0x00000000; w_idx 0..63; w_last only at idx 63; blk_ready returns to 1 one cycle later.
- "abc" padded block (61626380, 14× 00000000, 00000018) → W[0] = 0x61626380, W[15] = 0x00000018, W[16] = 0x61626380, W[17] = 0x000F0000, W[18] = 0x7DA86405, W[63] = 0x12B1EDEB.
- "abc" block with w_ready low for 3 cycles at idx 20 and idx 63 → outputs frozen during the stall; the word sequence is identical to the unstalled run.
- rst_n pulsed low at idx 30 → w_valid = 0 immediately (async); blk_ready = 1 after release. A fresh zero block then yields idx 0 with data 0.
- Two blocks offered back-to-back (blk_valid held high):
  - Macro off: one-cycle gap after idx 63.
  - Macro on: the next block's idx 0 follows idx 63 in the very next cycle.
- blk_valid toggled and blk_data changed during RUN → no effect on the emitted sequence; blk_ready stays 0 (macro off).

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
//
// Message-schedule stage that feeds the SHA-256 compression rounds. It takes
// one 512-bit padded block and emits the schedule words W[0..LAST_IDX] in
// round order, one word per w_valid/w_ready handshake. Only a 16-word
// sliding window is stored. W[16..] are generated from that window as the
// words are consumed.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   blk_valid  upstream block available
//   blk_ready  block accepted when blk_valid && blk_ready
//   blk_data   512-bit block, W[0] = bits 511:480 ... W[15] = bits 31:0
//   w_valid    w_data holds a valid schedule word
//   w_ready    downstream accepts the word when w_valid && w_ready
//   w_data     current schedule word W[t]
//   w_idx      index t of the current word
//   w_last     high with w_valid when w_idx == LAST_IDX
//
// Parameter
//   LAST_IDX   index of the final word. It must be 63 for SHA-256. The values
//              16..62 are only for debug benches.
//
// Build option
//   SHA256_SCHED_BACK2BACK_EN  when this macro is defined, the next block can
//              be accepted in the same cycle as the last word handshake, so
//              there is no idle cycle between blocks. When it is not defined,
//              blocks are accepted only in IDLE.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no block held; blk_ready = 1, w_valid = 0
// RUN   | emitting window[0] as W[t]; advances on each word handshake

module sha256_msg_schedule #(
    parameter int LAST_IDX = 63
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic [5:0]   w_idx,
    output logic         w_last
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] LAST = 6'(LAST_IDX);

    state_t      state_q, state_d;
    logic [5:0]  t_q, t_d;
    logic [31:0] win_q [16];
    logic [31:0] new_word;
    logic        load, shift;
    logic        blk_hs, w_hs, at_last;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign at_last = (t_q == LAST);
    assign w_valid = (state_q == RUN);
    assign w_last  = w_valid && at_last;
    assign w_data  = w_valid ? win_q[0] : 32'h0;
    assign w_idx   = t_q;
    assign w_hs    = w_valid && w_ready;

`ifdef SHA256_SCHED_BACK2BACK_EN
    assign blk_ready = (state_q == IDLE) || (w_last && w_ready);
`else
    assign blk_ready = (state_q == IDLE);
`endif

    assign blk_hs = blk_valid && blk_ready;

    // The window holds W[t..t+15]. This word is W[t+16].
    assign new_word = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= 6'd0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (blk_hs) begin
                    state_d = RUN;
                    t_d     = 6'd0;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (w_hs) begin
                    if (at_last) begin
                        // blk_hs can only be true here in the back-to-back build
                        t_d = 6'd0;
                        if (blk_hs) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shift = 1'b1;
                        t_d   = t_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'h0;
            end
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= blk_data[511 - 32*i -: 32];
            end
        end else if (shift) begin
            for (int i = 0; i < 15; i++) begin
                win_q[i] <= win_q[i+1];
            end
            win_q[15] <= new_word;
        end
    end

endmodule
